// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter
//   Granting side of the crossbar request/grant handshake. Picks one master
//   round-robin from the request vector and issues a registered one-hot
//   grant. A tenure lasts until the owner drops its request. Every tenure is
//   followed by at least one idle cycle (grant == 0) so that the crossbar
//   controller can clear ownership before a new owner is installed.
//
//   Optional feature macro: CROSSBAR_ARB_TIMEOUT_EN
//     Defined:   tenure limited to HOLD_MAX grant cycles. On expiry the grant
//                is force-released and timeout pulses for one cycle.
//     Undefined: no hold counter, no timeout port, tenure unbounded.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   request[N]   per-master request, bit i = master i wants the slave
//   grant[N]     registered one-hot (or zero) grant
//   grant_valid  registered OR of grant
//   owner        index of the granted master, holds last owner while idle
//   timeout      one-cycle pulse on forced release (macro builds only)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; arbitrate among current requests each cycle
// BUSY  | grant held for owner until it drops request (or hold expiry)

module dff #(
  parameter int            W   = 1,
  parameter logic [W-1:0]  RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end
endmodule

module crossbar_arbiter #(
  parameter int N = 16
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  , parameter int HOLD_MAX = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] owner
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  , output logic               timeout
`endif
);

  localparam int              OW   = $clog2(N);
  localparam logic [OW-1:0]   LAST = OW'(N - 1);
  localparam logic [N-1:0]    ONE  = N'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;

  logic          found;
  logic [OW-1:0] win;
  logic [OW-1:0] idx;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  localparam int            CW   = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Round-robin search starting just after ptr, wrapping at N-1 so that
  // indices >= N are never visited for non-power-of-2 N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    for (int k = 0; k < N; k++) begin
      if (!found && request[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = ONE << win;
          owner_d = win;
          state_d = S_BUSY;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
          // counter holds the number of grant cycles including the current one
          cnt_d   = CW'(1);
`endif
        end
      end
      S_BUSY: begin
        // release wins over expiry, so timeout only fires while still requested
        if (!request[owner_q]) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
`ifdef CROSSBAR_ARB_TIMEOUT_EN
        else if (cnt_q == HMAX) begin
          grant_d   = '0;
          ptr_d     = owner_q;
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  dff #(.W(1), .RST(S_IDLE)) u_state_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_d),
    .q     (state_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      owner_q       <= '0;
      ptr_q         <= LAST;
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
    end
  end

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Bench for crossbar_arbiter (N=16). Directed scenarios plus random request
// traffic, all checked against a cycle-level round-robin reference model.
// Build with CROSSBAR_ARB_TIMEOUT_EN to exercise the hold timeout (HOLD_MAX=4).

module tb_crossbar_arbiter;

  localparam int N = 16;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  localparam int HOLD = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] request;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  owner;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  crossbar_arbiter #(
    .N(N)
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    , .HOLD_MAX(HOLD)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner)
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    , .timeout   (timeout)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: who holds the slave, for how long, and who spoke last
  bit          m_busy;
  int          m_own;
  int          m_ptr;
  int          m_held;
  logic [15:0] m_grant;
  bit          m_to;

  function automatic void model_reset();
    m_busy  = 0;
    m_own   = 0;
    m_ptr   = N - 1;
    m_held  = 0;
    m_grant = '0;
    m_to    = 0;
  endfunction

  function automatic void model_step(input logic [15:0] r);
    m_to = 0;
    if (m_busy) begin
      if (!r[m_own]) begin
        m_busy = 0; m_grant = '0; m_ptr = m_own;
      end
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      else if (m_held >= HOLD) begin
        m_busy = 0; m_grant = '0; m_ptr = m_own; m_to = 1;
      end
`endif
      else m_held++;
    end else if (r != 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin
          m_own = c;
          break;
        end
      end
      m_busy  = 1;
      m_grant = 16'(1) << m_own;
      m_held  = 1;
    end
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_grant"}, grant, m_grant);
    chk({tag, "_owner"}, owner, m_own);
    chk({tag, "_gv"}, grant_valid, (m_grant != 0));
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    chk({tag, "_timeout"}, timeout, m_to);
`endif
  endtask

  task automatic cycle(input logic [15:0] r, input string tag);
    request = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    request = '0;
    rst_n   = 1'b0;
    model_reset();
    #7;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] drop, prev_exp, prev_dut, r;
    int consec, zeros;
    int order[$];
    int gaps[$];
    int exp_order[5] = '{0, 5, 10, 15, 0};

    // reset state
    request = '0;
    rst_n   = 1'b0;
    model_reset();
    #12;
    chk("rst_grant", grant, 16'h0000);
    chk("rst_gv", grant_valid, 1'b0);
    chk("rst_owner", owner, 4'd0);
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    chk("rst_timeout", timeout, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // single request, one-cycle latency, release
    cycle(16'h0001, "t1a");
    chk("t1_grant", grant, 16'h0001);
    chk("t1_owner", owner, 4'd0);
    chk("t1_gv", grant_valid, 1'b1);
    cycle(16'h0000, "t1b");
    chk("t1_release", grant, 16'h0000);

    // round-robin over 0,5,10,15 with 3-cycle tenures
    do_reset();
    drop = '0; prev_exp = '0; prev_dut = '0; consec = 0; zeros = 0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      cycle(16'h8421 & ~drop, "rr");
      drop = '0;
      if (m_grant != 0 && m_grant == prev_exp) consec++;
      else consec = (m_grant != 0) ? 1 : 0;
      prev_exp = m_grant;
      if (consec == 3) drop = m_grant;
      if (grant != 0 && prev_dut == 0) begin
        order.push_back(int'(owner));
        gaps.push_back(zeros);
        zeros = 0;
      end
      if (grant == 0) zeros++;
      prev_dut = grant;
    end
    chk("rr_tenures", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) begin
      chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      if (i > 0) chk($sformatf("rr_gap%0d", i), gaps[i], 1);
    end
    cycle(16'h0000, "rr_end0");
    cycle(16'h0000, "rr_end1");

    // owner holds against a competing request
    cycle(16'h0008, "hold_a");
    chk("hold_first", grant, 16'h0008);
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0018, "hold_b");
      chk("hold_keep", grant, 16'h0008);
    end
    cycle(16'h0010, "hold_c");
    chk("hold_idle", grant, 16'h0000);
    cycle(16'h0010, "hold_d");
    chk("hold_next", grant, 16'h0010);
    cycle(16'h0000, "hold_e");
    cycle(16'h0000, "hold_f");

    // pointer wrap from 15 to 0
    cycle(16'h8000, "wrap_a");
    chk("wrap_m15", grant, 16'h8000);
    cycle(16'h0000, "wrap_b");
    cycle(16'h8001, "wrap_c");
    chk("wrap_m0", grant, 16'h0001);
    cycle(16'h0000, "wrap_d");
    cycle(16'h0000, "wrap_e");

    // asynchronous reset mid-tenure
    cycle(16'h0040, "arst_a");
    chk("arst_pre", grant, 16'h0040);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 16'h0000);
    chk("arst_gv", grant_valid, 1'b0);
    model_reset();
    request = 16'h0041;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(16'h0041, "arst_b");
    chk("arst_restart", grant, 16'h0001);
    cycle(16'h0000, "arst_c");

    // long hold: timeout with macro, unbounded without
    do_reset();
    cycle(16'h0084, "to_a");
    chk("to_first", grant, 16'h0004);
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0084, "to_b");
      chk("to_hold", grant, 16'h0004);
    end
    cycle(16'h0084, "to_c");
    chk("to_release", grant, 16'h0000);
    chk("to_pulse", timeout, 1'b1);
    cycle(16'h0084, "to_d");
    chk("to_next", grant, 16'h0080);
    chk("to_pulse_end", timeout, 1'b0);
`else
    for (int i = 0; i < 10; i++) begin
      cycle(16'h0084, "nto");
      chk("nto_hold", grant, 16'h0004);
    end
`endif
    cycle(16'h0000, "to_e");
    cycle(16'h0000, "to_f");

    // random traffic against the model
    r = 16'(($urandom()));
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 31) == 0) r = '0;
      cycle(r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossbar_arbiter.md
Name: crossbar_arbiter

Overview:
- Granting side of the crossbar request/grant handshake: takes the per-master request vector and issues a one-hot, registered grant.
- Round-robin fairness; holds the grant for a master until that master drops its request.
- Sits beside the per-slave crossbar controller, which consumes the same request and grant vectors to set and clear crossbar ownership.

Parameters:
- N, 16, number of requesting masters (2..16).
- HOLD_MAX, 256, maximum consecutive grant cycles per tenure; used only when CROSSBAR_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request  input  N  per-master request; bit i high = master i wants the slave.
- grant  output  N  one-hot (or zero) registered grant.
- grant_valid  output  1  OR of grant, registered.
- owner  output  $clog2(N)  index of the granted master; holds the last owner when grant is zero.
- timeout  output  1  one-cycle pulse on forced release; present only with CROSSBAR_ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n low): grant=0, grant_valid=0, owner=0, timeout=0, state=S_IDLE, priority pointer ptr=N-1, so master 0 wins first.
- States: S_IDLE, S_BUSY. The state register uses the codebase dff primitive.
- S_IDLE, request==0: stay in S_IDLE; grant stays 0.
- S_IDLE, request!=0: winner = first set bit searching ptr+1, ptr+2, … modulo N (wrap from N-1 to 0).
  - Next edge: grant=onehot(winner), owner=winner, grant_valid=1, state=S_BUSY.
  - Latency is exactly 1 cycle from request sampled to grant visible.
- S_BUSY, request[owner]==1: hold grant, owner and state. Requests from other masters are ignored.
- S_BUSY, request[owner]==0: next edge grant=0, grant_valid=0, ptr=owner, state=S_IDLE.
  - At least one idle cycle (grant==0) always separates two tenures, even to a different master.
  - This gives the crossbar controller its clear-owner cycle.
- Simultaneous release plus new request in the same cycle: release takes effect first. The new winner is chosen in the following S_IDLE cycle, using the updated ptr.
- Same master re-requests after release: wins only if no other master requests on the arbitration cycle, since it has the lowest priority after ptr update.
- grant never has more than one bit set.
- grant is never asserted to a master whose request was low on the arbitration cycle.
- Request bits that drop in S_IDLE before arbitration are simply not considered. No latching of requests.
- owner arithmetic: modulo N. For non-power-of-2 N, indices >= N are never produced.
- Reset asserted mid-tenure: grant drops immediately (asynchronously). After release, arbitration restarts from master 0.

Optional Feature:
- Macro CROSSBAR_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(HOLD_MAX+1)) clears on entry to S_BUSY and increments each S_BUSY cycle.
  - When the counter reaches HOLD_MAX while request[owner] is still 1, the next edge does all of the following:
    - grant=0
    - timeout=1 for one cycle
    - ptr=owner
    - state=S_IDLE
  - The forced-off master must re-arbitrate normally.
  - Normal release in the same cycle as expiry is treated as a normal release: timeout stays 0.
- Undefined: no counter, no timeout port; a tenure is unbounded.

Test Plan:
- Reset then request=16'h0001 → grant=16'h0001, owner=0, grant_valid=1 one cycle later; drop request → grant=0 next cycle.
- request=16'h8421 held, each master releasing after 3 granted cycles and re-requesting one cycle later → grant order 0,5,10,15,0 with exactly one zero-grant cycle between tenures.
- Master 3 owns; request=16'h0018 (master 4 also asserts) → grant stays 16'h0008 until bit 3 drops. Then an idle cycle, then grant=16'h0010.
- Wrap: ptr=15 (after master 15 releases), request=16'h8001 → grant=16'h0001.
- Reset asserted while grant=16'h0040 → grant=0 without a clock edge. After release with request=16'h0041 → grant=16'h0001.
- With CROSSBAR_ARB_TIMEOUT_EN, HOLD_MAX=4, master 2 holds request continuously, master 7 requests:
  - grant=16'h0004 for 4 cycles, then timeout pulse and grant=0.
  - Then grant=16'h0080.
  - Without the macro, master 2 keeps the grant indefinitely.
